// File: rtl/fan_row_accumulator_pkg.sv
// fan_row_accumulator_pkg
//   Shared widths, line field layout, state encoding and arithmetic helpers
//   for the fan_adder output path. The line is packed as {ctrl, row, data}.
package fan_row_accumulator_pkg;

  localparam int DW_DATA = 8;
  localparam int DW_ROW  = 5;
  localparam int DW_CTRL = 4;
  localparam int DW_LINE = DW_DATA + DW_ROW + DW_CTRL;
  localparam int DW_ACC  = 20;
  localparam int NUM_ROW = 1 << DW_ROW;

  localparam int CTRL_VALID_BIT = 3;
  localparam int CTRL_LAST_BIT  = 0;

  localparam logic signed [DW_ACC-1:0] ACC_MAX = {1'b0, {(DW_ACC-1){1'b1}}};
  localparam logic signed [DW_ACC-1:0] ACC_MIN = {1'b1, {(DW_ACC-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [DW_CTRL-1:0] line_ctrl(input logic [DW_LINE-1:0] l);
    return l[DW_LINE-1 -: DW_CTRL];
  endfunction

  function automatic logic [DW_ROW-1:0] line_row(input logic [DW_LINE-1:0] l);
    return l[DW_DATA +: DW_ROW];
  endfunction

  function automatic logic signed [DW_DATA-1:0] line_data(input logic [DW_LINE-1:0] l);
    return l[DW_DATA-1:0];
  endfunction

  function automatic logic signed [DW_ACC-1:0] sext_data(input logic signed [DW_DATA-1:0] d);
    return {{(DW_ACC-DW_DATA){d[DW_DATA-1]}}, d};
  endfunction

  function automatic logic [NUM_ROW-1:0] row_onehot(input logic [DW_ROW-1:0] r);
    logic [NUM_ROW-1:0] m;
    m = '0;
    m[r] = 1'b1;
    return m;
  endfunction

  // One guard bit catches overflow; clamp instead of wrapping.
  function automatic logic signed [DW_ACC-1:0] sat_add(input logic signed [DW_ACC-1:0] a,
                                                       input logic signed [DW_ACC-1:0] b);
    logic signed [DW_ACC:0] s;
    s = {a[DW_ACC-1], a} + {b[DW_ACC-1], b};
    if (s[DW_ACC] != s[DW_ACC-1]) begin
      return s[DW_ACC] ? ACC_MIN : ACC_MAX;
    end else begin
      return s[DW_ACC-1:0];
    end
  endfunction

endpackage

// File: rtl/fan_prio_enc.sv
// fan_prio_enc
//   Lowest-set-bit finder over a mask.
//   mask : input bit vector (N bits)
//   idx  : index of the lowest set bit (0 when mask is empty)
//   any  : high when at least one bit of mask is set
module fan_prio_enc #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic [N-1:0] mask,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from the top down so the lowest set bit is the final assignment.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = mask[i] ? W'(i) : idx;
    end
    any = |mask;
  end

endmodule

// File: rtl/fan_row_accumulator.sv
// fan_row_accumulator
//   Accumulates sign-extended fan_adder lines into a per-row saturating
//   partial-sum buffer; on a last-of-tile line drains every touched row in
//   ascending order over a valid/ready stream, pulses tile_done, then
//   returns to accumulation with an empty buffer.
//   clk, rst_n : clock, synchronous active-low reset
//   in_line    : {ctrl, row, data} from fan_adder
//   in_ready   : high while lines are being accepted (ACCUM)
//   out_valid / out_ready / out_row / out_data : drained row stream
//   tile_done  : one-cycle pulse after the final row of a tile is accepted
module fan_row_accumulator
  import fan_row_accumulator_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DW_LINE-1:0]       in_line,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW_ROW-1:0]        out_row,
  output logic signed [DW_ACC-1:0] out_data,
  output logic                     tile_done
);

  state_t                    state_r;
  logic signed [DW_ACC-1:0]  acc_r [NUM_ROW];
  logic [NUM_ROW-1:0]        touched_r;
  logic                      in_ready_r;
  logic                      out_valid_r;
  logic [DW_ROW-1:0]         out_row_r;
  logic signed [DW_ACC-1:0]  out_data_r;
  logic                      tile_done_r;

  logic [DW_CTRL-1:0]        ctrl_s;
  logic                      ctrl_unused_s;
  logic [DW_ROW-1:0]         row_s;
  logic                      line_valid_s;
  logic                      line_last_s;
  logic signed [DW_ACC-1:0]  sum_s;
  logic                      accept_s;
  logic [NUM_ROW-1:0]        mask_s;
  logic [DW_ROW-1:0]         idx_s;
  logic                      any_s;

  assign ctrl_s        = line_ctrl(in_line);
  assign ctrl_unused_s = ^ctrl_s[2:1];  // reserved ctrl bits, not decoded
  assign row_s         = line_row(in_line);
  assign line_valid_s  = ctrl_s[CTRL_VALID_BIT];
  assign line_last_s   = ctrl_s[CTRL_LAST_BIT];
  assign sum_s         = sat_add(acc_r[row_s], sext_data(line_data(in_line)));
  assign accept_s      = out_valid_r & out_ready;

  // Touched mask as it will be after this edge; the encoder looks at it so the
  // next output row can be registered in the same cycle.
  always_comb begin
    mask_s = touched_r;
    if (state_r == ST_ACCUM && line_valid_s) begin
      mask_s = touched_r | row_onehot(row_s);
    end else if (state_r == ST_DRAIN && accept_s) begin
      mask_s = touched_r & ~row_onehot(out_row_r);
    end else begin
      mask_s = touched_r;
    end
  end

  fan_prio_enc #(
    .N (NUM_ROW),
    .W (DW_ROW)
  ) u_prio (
    .mask (mask_s),
    .idx  (idx_s),
    .any  (any_s)
  );

  // Control FSM, partial-sum buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_ACCUM;
      for (int i = 0; i < NUM_ROW; i++) begin
        acc_r[i] <= '0;
      end
      touched_r   <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_row_r   <= '0;
      out_data_r  <= '0;
      tile_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_ACCUM: begin
          tile_done_r <= 1'b0;
          if (line_valid_s) begin
            acc_r[row_s] <= sum_s;
            touched_r    <= mask_s;
            if (line_last_s) begin
              // The row just written may be the lowest one; forward its new sum.
              state_r     <= ST_DRAIN;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
              out_row_r   <= idx_s;
              out_data_r  <= (idx_s == row_s) ? sum_s : acc_r[idx_s];
            end else begin
              state_r <= ST_ACCUM;
            end
          end else begin
            state_r <= ST_ACCUM;
          end
        end
        ST_DRAIN: begin
          if (accept_s) begin
            acc_r[out_row_r] <= '0;
            touched_r        <= mask_s;
            if (any_s) begin
              out_row_r  <= idx_s;
              out_data_r <= acc_r[idx_s];
            end else begin
              out_valid_r <= 1'b0;
              out_row_r   <= '0;
              out_data_r  <= '0;
              tile_done_r <= 1'b1;
              state_r     <= ST_DONE;
            end
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          tile_done_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_ACCUM;
        end
        default: begin
          state_r     <= ST_ACCUM;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          tile_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_row   = out_row_r;
  assign out_data  = out_data_r;
  assign tile_done = tile_done_r;

endmodule
